// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier
//  Purpose  : Sequential unsigned multiplier using shift-and-add. One partial
//             product is accumulated per RUN cycle. The step count is owned by
//             an external counter, which raises counter_flag on the last step.
//  Ports    : clk            - clock, rising edge
//             reset          - synchronous active-high reset
//             start          - launch request, honoured in IDLE only
//             multiplicand   - operand A (WORD_LENGTH bits, unsigned)
//             multiplier     - operand B (WORD_LENGTH bits, unsigned)
//             counter_flag   - terminal count from the step counter
//             counter_enable - step counter enable, high during RUN
//             product        - last completed result (2*WORD_LENGTH bits)
//             done           - one-cycle pulse, product is new and valid
//             busy           - high in RUN and DONE
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int WORD_LENGTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  input  logic                       counter_flag,
  output logic                       counter_enable,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       done,
  output logic                       busy
);

  localparam int c_PW = 2 * WORD_LENGTH;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [c_PW-1:0]        r_acc;
  logic [c_PW-1:0]        r_a;
  logic [WORD_LENGTH-1:0] r_b;
  logic [c_PW-1:0]        r_product;
  logic [c_PW-1:0]        w_acc_next;

  // Accumulator after the current step: add the shifted multiplicand when
  // the current multiplier LSB is set.
  assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start)        w_state_next = c_RUN;
      c_RUN:   if (counter_flag) w_state_next = c_DONE;
      c_DONE:                    w_state_next = c_IDLE;
      default:                   w_state_next = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the state register only
  // --------------------------------------------------------------------------
  always_comb begin
    counter_enable = 1'b0;
    done           = 1'b0;
    busy           = 1'b0;
    case (r_state)
      c_RUN: begin
        counter_enable = 1'b1;
        busy           = 1'b1;
      end
      c_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        counter_enable = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_a   <= {{WORD_LENGTH{1'b0}}, multiplicand};
            r_b   <= multiplier;
          end
        end
        c_RUN: begin
          r_acc <= w_acc_next;
          r_a   <= {r_a[c_PW-2:0], 1'b0};
          r_b   <= r_b >> 1;
          // Capture the final step's sum on the edge entering DONE so the
          // product register is already valid while done is high.
          if (counter_flag) begin
            r_product <= w_acc_next;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_multiplier
//  Purpose  : Self-checking bench for shift_add_multiplier (WORD_LENGTH=3).
//             A behavioural model predicts every output each cycle; directed
//             operations are additionally pinned against literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

  localparam int WL = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic [WL-1:0] multiplicand;
  logic [WL-1:0] multiplier;
  logic          counter_flag;
  logic          counter_enable;
  logic [2*WL-1:0] product;
  logic          done;
  logic          busy;

  shift_add_multiplier #(.WORD_LENGTH(WL)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .counter_flag   (counter_flag),
    .counter_enable (counter_enable),
    .product        (product),
    .done           (done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: operation phase plus the arithmetic product A*B.
  // --------------------------------------------------------------------------
  int          m_phase = 0;   // 0 waiting, 1 stepping, 2 result cycle
  int          m_expect = 0;
  int          m_prod = 0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_prod  <= 0;
      m_valid <= 1'b1;
    end else begin
      if (m_phase == 0 && start) begin
        m_expect <= int'(multiplicand) * int'(multiplier);
        m_phase  <= 1;
      end else if (m_phase == 1 && counter_flag) begin
        m_prod  <= m_expect;
        m_phase <= 2;
      end else if (m_phase == 2) begin
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("product",        32'(product),        32'(m_prod));
      check("done",           32'(done),           32'(m_phase == 2));
      check("busy",           32'(busy),           32'(m_phase != 0));
      check("counter_enable", 32'(counter_enable), 32'(m_phase == 1));
    end
  end

  // Observation counters used by the literal checks.
  int          n_done = 0;
  int          n_busy = 0;
  int          n_ce   = 0;
  logic [5:0]  done_prod [8];

  always @(negedge clk) begin
    if (busy)           n_busy <= n_busy + 1;
    if (counter_enable) n_ce   <= n_ce + 1;
    if (done) begin
      done_prod[n_done % 8] <= product;
      n_done <= n_done + 1;
    end
  end

  // Inputs change 2 time units after a rising edge; sampled at the next one.
  task automatic drive(input bit rs, input bit st, input int a, input int b, input bit fl);
    @(posedge clk);
    #2;
    reset        = rs;
    start        = st;
    multiplicand = WL'(a);
    multiplier   = WL'(b);
    counter_flag = fl;
  endtask

  // One operation: start for one cycle, flag on the 3rd RUN cycle.
  task automatic run_op(input int a, input int b, input bit fl_idle, input int exp_p, input string tag);
    int d0, b0, c0;
    d0 = n_done; b0 = n_busy; c0 = n_ce;
    drive(0, 1, a, b, fl_idle);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check({tag, "_done_count"}, 32'(n_done - d0), 1);
    check({tag, "_product"},    32'(done_prod[(n_done - 1) % 8]), 32'(exp_p));
    check({tag, "_busy_cycles"}, 32'(n_busy - b0), 4);
    check({tag, "_ce_cycles"},  32'(n_ce - c0), 3);
  endtask

  initial begin
    int d0, b0;
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; counter_flag = 1'b0;
    drive(1, 1, 5, 7, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("reset_product", 32'(product), 0);
    check("reset_busy",    32'(busy), 0);
    check("reset_done",    32'(done), 0);

    run_op(5, 7, 0, 35, "op5x7");
    run_op(7, 7, 0, 49, "op7x7");
    run_op(0, 6, 0, 0,  "op0x6");
    run_op(6, 1, 0, 6,  "op6x1");
    check("hold_after_6x1", 32'(product), 6);

    // Start re-asserted while running with other operands.
    d0 = n_done;
    drive(0, 1, 5, 7, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("ignore_start_done", 32'(n_done - d0), 1);
    check("ignore_start_prod", 32'(product), 35);

    // Reset on the 2nd RUN cycle aborts the operation.
    d0 = n_done;
    drive(0, 1, 5, 7, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("abort_product", 32'(product), 0);
    check("abort_busy",    32'(busy), 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("abort_no_done", 32'(n_done - d0), 0);
    run_op(3, 3, 0, 9, "op3x3");

    // Start held high: two back-to-back operations.
    d0 = n_done; b0 = n_busy;
    drive(0, 1, 2, 3, 0);
    drive(0, 1, 2, 3, 0);
    drive(0, 1, 2, 3, 0);
    drive(0, 1, 2, 3, 1);
    drive(0, 1, 3, 3, 0);
    drive(0, 1, 3, 3, 0);
    drive(0, 1, 3, 3, 0);
    drive(0, 1, 3, 3, 0);
    drive(0, 0, 3, 3, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("b2b_done_count", 32'(n_done - d0), 2);
    check("b2b_first",      32'(done_prod[d0 % 8]), 6);
    check("b2b_second",     32'(done_prod[(d0 + 1) % 8]), 9);
    check("b2b_busy",       32'(n_busy - b0), 8);

    // counter_flag high throughout IDLE must not move the FSM.
    b0 = n_busy;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("flag_idle_busy", 32'(n_busy - b0), 0);
    run_op(6, 5, 1, 30, "op6x5");

    drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
